entropy_key_generator: RTL and testbench

- Sits directly downstream of the AC97 parity-bit randomness extractor.
- Watches the same AC97 `ready` strobe to count fresh entropy bits.
- After a requested number of full 256-bit passes over the extractor buffer, it folds each pass's buffer snapshot into a 256-bit accumulator.
- Presents the result as a session key to the phone's crypto/handshake logic through a valid/ack handshake.

---
 rtl/entropy_key_generator_if.sv | 26 ++
 rtl/entropy_key_generator.sv | 122 ++++++++++++
 tb/tb_entropy_key_generator.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/entropy_key_generator_if.sv
// Handshake bundle between the AC97 entropy extractor, the key generator
// and the crypto/handshake consumer.
`timescale 1ns/1ps
interface entropy_key_generator_if #(
    parameter int BUF_WIDTH = 256
);
    logic                 ready;
    logic [BUF_WIDTH-1:0] entropy_buffer;
    logic                 request;
    logic                 key_ack;
    logic [BUF_WIDTH-1:0] key_out;
    logic                 key_valid;
    logic                 busy;

    // Driver side: extractor/consumer environment.
    modport master (
        output ready, entropy_buffer, request, key_ack,
        input  key_out, key_valid, busy
    );

    // Key generator side.
    modport slave (
        input  ready, entropy_buffer, request, key_ack,
        output key_out, key_valid, busy
    );
endinterface

// File: rtl/entropy_key_generator.sv
// Counts AC97 ready edges and folds the extractor buffer into a 256-bit
// accumulator once per full pass; after PASSES folds presents it as a key.
`timescale 1ns/1ps
module entropy_key_generator #(
    parameter int PASSES    = 4,
    parameter int BUF_WIDTH = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    entropy_key_generator_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VALID
    } state_e;

    localparam logic [3:0] PASS_LAST = 4'(PASSES);

    state_e               state_q, state_d;
    logic                 prev_ready_q, prev_ready_d;
    logic [7:0]           edge_cnt_q, edge_cnt_d;
    logic [3:0]           pass_cnt_q, pass_cnt_d;
    logic [1:0]           fold_pipe_q, fold_pipe_d;
    logic [BUF_WIDTH-1:0] acc_q, acc_d;
    logic [BUF_WIDTH-1:0] key_out_q, key_out_d;
    logic                 key_valid_q, key_valid_d;

    logic                 ready_edge;
    logic                 pass_wrap;
    logic [BUF_WIDTH-1:0] acc_fold;

    always_comb begin
        ready_edge = bus.ready & ~prev_ready_q;
        pass_wrap  = ready_edge && (edge_cnt_q == 8'hFF);
        acc_fold   = {acc_q[BUF_WIDTH-2:0], acc_q[BUF_WIDTH-1]} ^ bus.entropy_buffer;
    end

    // NOTE: every signal gets its hold value before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        prev_ready_d = bus.ready;
        edge_cnt_d   = edge_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        fold_pipe_d  = fold_pipe_q;
        acc_d        = acc_q;
        key_out_d    = key_out_q;
        key_valid_d  = key_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                key_valid_d = 1'b0;
                fold_pipe_d = '0;
                if (bus.request) begin
                    acc_d      = '0;
                    edge_cnt_d = '0;
                    pass_cnt_d = '0;
                    state_d    = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (ready_edge) begin
                    edge_cnt_d = edge_cnt_q + 8'd1;
                end
                // Fold two cycles after the wrap so the extractor's last write lands.
                fold_pipe_d = {fold_pipe_q[0], pass_wrap};
                if (fold_pipe_q[1]) begin
                    acc_d      = acc_fold;
                    pass_cnt_d = pass_cnt_q + 4'd1;
                    if (pass_cnt_d == PASS_LAST) begin
                        key_out_d   = acc_fold;
                        fold_pipe_d = '0;
                        state_d     = ST_VALID;
                    end
                end
            end

            ST_VALID: begin
                key_valid_d = 1'b1;
                fold_pipe_d = '0;
                if (key_valid_q && bus.key_ack) begin
                    key_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prev_ready_q <= 1'b1;
            edge_cnt_q   <= '0;
            pass_cnt_q   <= '0;
            fold_pipe_q  <= '0;
            acc_q        <= '0;
            key_out_q    <= '0;
            key_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_ready_q <= prev_ready_d;
            edge_cnt_q   <= edge_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            fold_pipe_q  <= fold_pipe_d;
            acc_q        <= acc_d;
            key_out_q    <= key_out_d;
            key_valid_q  <= key_valid_d;
        end
    end

    assign bus.key_out   = key_out_q;
    assign bus.key_valid = key_valid_q;
    assign bus.busy      = (state_q == ST_COLLECT);
endmodule

// File: tb/tb_entropy_key_generator.sv
// Randomized scoreboard bench: two generators (PASSES=1 and PASSES=2) share
// the ready strobe and buffer; a pass-level model predicts each key.
`timescale 1ns/1ps
module tb_entropy_key_generator;
    localparam int W = 256;

    logic clock = 1'b0;
    logic reset;
    logic ready;
    logic [W-1:0] ebuf;
    logic req1, req2, ack1, ack2;

    always #5 clock = ~clock;

    entropy_key_generator_if #(.BUF_WIDTH(W)) bus1 ();
    entropy_key_generator_if #(.BUF_WIDTH(W)) bus2 ();

    assign bus1.ready          = ready;
    assign bus1.entropy_buffer = ebuf;
    assign bus1.request        = req1;
    assign bus1.key_ack        = ack1;
    assign bus2.ready          = ready;
    assign bus2.entropy_buffer = ebuf;
    assign bus2.request        = req2;
    assign bus2.key_ack        = ack2;

    entropy_key_generator #(.PASSES(1), .BUF_WIDTH(W)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );
    entropy_key_generator #(.PASSES(2), .BUF_WIDTH(W)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_edge_cyc = 0;
    int key_seen [1:2];
    int seen_start [1:2];
    logic kv_prev [1:2];

    logic [W-1:0] exp_q1 [$];
    logic [W-1:0] exp_q2 [$];

    // Pass-level reference model for the generator currently running.
    bit           model_active = 1'b0;
    int           model_dut = 0;
    int           model_target = 0;
    int           model_edges = 0;
    int           model_passes = 0;
    logic [W-1:0] model_acc = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] rotl1(input logic [W-1:0] v);
        return (v << 1) | (v >> (W - 1));
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic monitor(input int d, input logic kv, input logic bsy, input logic [W-1:0] ko);
        logic [W-1:0] exp;
        if (kv === 1'b1 && kv_prev[d] !== 1'b1) begin
            key_seen[d]++;
            check($sformatf("latency_dut%0d", d), W'(cyc - last_edge_cyc), W'(3));
            check($sformatf("busy_at_valid_dut%0d", d), W'(bsy), '0);
            if ((d == 1 ? exp_q1.size() : exp_q2.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_key_dut%0d actual=%0h required=none", d, ko);
            end else begin
                exp = (d == 1) ? exp_q1.pop_front() : exp_q2.pop_front();
                check($sformatf("key_dut%0d", d), ko, exp);
            end
        end
        kv_prev[d] = kv;
    endtask

    always @(negedge clock) begin
        monitor(1, bus1.key_valid, bus1.busy, bus1.key_out);
        monitor(2, bus2.key_valid, bus2.busy, bus2.key_out);
    end

    task automatic model_edge(input logic [W-1:0] fold_val);
        if (!model_active) return;
        model_edges++;
        if (model_edges == 256) begin
            model_edges = 0;
            model_acc   = rotl1(model_acc) ^ fold_val;
            model_passes++;
            if (model_passes == model_target) begin
                if (model_dut == 1) exp_q1.push_back(model_acc);
                else                exp_q2.push_back(model_acc);
                model_active = 1'b0;
            end
        end
    endtask

    task automatic start(input int d);
        model_active = 1'b1;
        model_dut    = d;
        model_target = d;
        model_edges  = 0;
        model_passes = 0;
        model_acc    = '0;
        seen_start[d] = key_seen[d];
        if (d == 1) req1 = 1'b1; else req2 = 1'b1;
        tick();
        req1 = 1'b0;
        req2 = 1'b0;
        check($sformatf("busy_after_request_dut%0d", d), W'(d == 1 ? bus1.busy : bus2.busy), W'(1));
    endtask

    // One ready pulse; the buffer value is set with the rising edge and may be
    // rewritten one cycle after the edge (extractor's final write).
    task automatic pulse(input logic [W-1:0] b, input bit late, input logic [W-1:0] late_b);
        ebuf = b;
        ready = 1'b1;
        last_edge_cyc = cyc + 1;
        tick();
        tick();
        model_edge(late ? late_b : b);
        if (late) ebuf = late_b;
        ready = 1'b0;
        tick();
        if ($urandom_range(0, 1) == 1) tick();
    endtask

    task automatic pulses_const(input int n, input logic [W-1:0] b);
        for (int i = 0; i < n; i++) pulse(b, 1'b0, '0);
    endtask

    task automatic pulses_rand(input int n);
        for (int i = 0; i < n; i++) pulse(rand_w(), ($urandom_range(0, 3) == 0), rand_w());
    endtask

    task automatic wait_key(input int d);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (key_seen[d] > seen_start[d]) got = 1'b1;
            else tick();
        end
        check($sformatf("key_arrived_dut%0d", d), W'(got), W'(1));
    endtask

    task automatic do_ack(input int d, input logic [W-1:0] exp_key);
        if (d == 1) ack1 = 1'b1; else ack2 = 1'b1;
        tick();
        ack1 = 1'b0;
        ack2 = 1'b0;
        check($sformatf("valid_after_ack_dut%0d", d), W'(d == 1 ? bus1.key_valid : bus2.key_valid), '0);
        check($sformatf("key_kept_after_ack_dut%0d", d), d == 1 ? bus1.key_out : bus2.key_out, exp_key);
        check($sformatf("busy_after_ack_dut%0d", d), W'(d == 1 ? bus1.busy : bus2.busy), '0);
    endtask

    initial begin
        logic [W-1:0] pat_a, pat_b, ones, held, bconst;
        pat_a = {64{4'hA}};
        pat_b = {128{2'b01}};
        ones  = {W{1'b1}};
        key_seen[1] = 0;   key_seen[2] = 0;
        seen_start[1] = 0; seen_start[2] = 0;
        kv_prev[1] = 1'b0; kv_prev[2] = 1'b0;
        reset = 1'b1; ready = 1'b1; ebuf = '0;
        req1 = 1'b0; req2 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;

        // Reset with ready high, released with ready still high.
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("rst_valid_dut1", W'(bus1.key_valid), '0);
        check("rst_busy_dut1", W'(bus1.busy), '0);
        check("rst_key_dut1", bus1.key_out, '0);
        check("rst_valid_dut2", W'(bus2.key_valid), '0);
        check("rst_busy_dut2", W'(bus2.busy), '0);
        check("rst_key_dut2", bus2.key_out, '0);
        ready = 1'b0;
        tick();

        // Single pass, constant buffer.
        start(1);
        pulses_const(256, pat_a);
        wait_key(1);
        do_ack(1, pat_a);

        // Two passes of a constant pattern fold to all ones; valid held until ack.
        start(2);
        pulses_const(512, pat_b);
        wait_key(2);
        repeat (5) tick();
        check("valid_held_dut2", W'(bus2.key_valid), W'(1));
        do_ack(2, ones);

        // Final extractor write lands one cycle after the 256th edge.
        start(1);
        pulses_const(255, '0);
        pulse('0, 1'b1, W'(1));
        wait_key(1);
        do_ack(1, W'(1));

        // Request during COLLECT is ignored; edges in VALID are ignored.
        start(2);
        pulses_rand(100);
        req2 = 1'b1;
        tick();
        req2 = 1'b0;
        check("busy_after_ignored_request", W'(bus2.busy), W'(1));
        pulses_rand(412);
        wait_key(2);
        held = bus2.key_out;
        pulses_rand(300);
        check("valid_kept_in_valid", W'(bus2.key_valid), W'(1));
        check("key_kept_in_valid", bus2.key_out, held);
        do_ack(2, held);

        // Random single-pass runs with random late writes.
        for (int r = 0; r < 3; r++) begin
            start(1);
            pulses_rand(256);
            wait_key(1);
            held = bus1.key_out;
            do_ack(1, held);
        end

        // Reset mid-operation discards partial work.
        start(2);
        pulses_rand(300);
        reset = 1'b1;
        model_active = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("midrst_valid", W'(bus2.key_valid), '0);
        check("midrst_busy", W'(bus2.busy), '0);
        check("midrst_key", bus2.key_out, '0);
        bconst = rand_w();
        start(2);
        pulses_const(512, bconst);
        wait_key(2);
        do_ack(2, rotl1(bconst) ^ bconst);

        repeat (4) tick();
        check("scoreboard_empty_dut1", W'(exp_q1.size()), '0);
        check("scoreboard_empty_dut2", W'(exp_q2.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
